// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer frame averager.
// Imported by the top and the per-axis accumulator.
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DROP,
    ACCUM
  } state_t;

  localparam int BYTES_PER_FRAME = 3;
  localparam int NUM_AXES        = 3;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;

endpackage

// File: rtl/accel_frame_averager_axis.sv
// One axis: signed running sum over the window, then the
// floored average split into sign and saturated magnitude.
module axis_accumulator
  import accel_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add_en,
  input  logic       clr,
  input  logic [7:0] sample,
  output logic [7:0] avg,
  output logic [6:0] mag,
  output logic       neg
);

  localparam int AW = 8 + AVG_LOG2;

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_ext;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_shr;
  logic        [7:0]    w_avg;
  logic        [7:0]    w_inv;
  logic        [6:0]    w_mag;

  assign w_ext = AW'($signed(sample));
  assign w_sum = r_acc + w_ext;
  assign w_shr = w_sum >>> AVG_LOG2;
  assign w_avg = 8'(w_shr);
  assign w_inv = 8'd0 - w_avg;

  // Magnitude of the average; -128 has no positive twin so clamp to 127.
  always_comb begin
    w_mag = w_avg[6:0];
    if (w_avg[7]) begin
      w_mag = (w_avg == 8'h80) ? 7'h7f : w_inv[6:0];
    end
  end

  // Add the sample; on the closing sample publish and restart the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      avg   <= '0;
      mag   <= '0;
      neg   <= 1'b0;
    end else if (add_en) begin
      if (clr) begin
        r_acc <= '0;
        avg   <= w_avg;
        mag   <= w_mag;
        neg   <= w_avg[7];
      end else begin
        r_acc <= w_sum;
      end
    end
  end

endmodule

// File: rtl/accel_frame_averager.sv
// Assembles X/Y/Z bytes of each SPI read burst into a sample and
// averages 2^AVG_LOG2 samples per axis for the display decoders.
module accel_frame_averager
  import accel_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [7:0] x_avg,
  output logic [7:0] y_avg,
  output logic [7:0] z_avg,
  output logic [6:0] x_mag,
  output logic [6:0] y_mag,
  output logic [6:0] z_mag,
  output logic       x_neg,
  output logic       y_neg,
  output logic       z_neg,
  output logic       out_valid,
  output logic       frame_err
);

  localparam logic [4:0] WIN_LAST =
    5'((1 << AVG_LOG2) - 1);
  localparam logic [1:0] IDX_LAST =
    2'(BYTES_PER_FRAME - 1);

  state_t r_state;
  state_t w_state_nx;

  logic [1:0] r_idx;
  logic [1:0] w_idx_nx;
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_nx;

  logic [NUM_AXES-1:0][7:0] r_hold;
  logic [NUM_AXES-1:0]      w_cap;

  logic w_err_nx;
  logic w_add;
  logic w_last;
  logic r_valid;
  logic r_err;

  // Next state, byte steering and window bookkeeping.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    w_cap      = '0;
    w_err_nx   = 1'b0;
    w_add      = 1'b0;
    w_last     = 1'b0;

    if (r_state == ACCUM) begin
      w_add      = 1'b1;
      w_last     = (r_cnt == WIN_LAST);
      w_cnt_nx   = w_last ? 5'd0 : r_cnt + 5'd1;
      w_state_nx = IDLE;
    end

    if (frame_start) begin
      w_state_nx = COLLECT;
      w_idx_nx   = 2'd0;
      if (byte_valid) begin
        w_cap[AXIS_X] = 1'b1;
        w_idx_nx      = 2'd1;
      end
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (byte_valid) begin
            w_cap[r_idx] = 1'b1;
            w_idx_nx     = r_idx + 2'd1;
          end
          if (byte_valid && r_idx == IDX_LAST) begin
            w_state_nx = frame_end ? ACCUM : DROP;
          end else if (frame_end) begin
            w_state_nx = IDLE;
            w_err_nx   = 1'b1;
          end
        end
        DROP: begin
          if (frame_end) w_state_nx = ACCUM;
        end
        default: begin
        end
      endcase
    end
  end

  // Control state, counters and one-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
      r_valid <= w_add & w_last;
      r_err   <= w_err_nx;
    end
  end

  // Holding registers for the axis bytes of the current burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else begin
      for (int a = 0; a < NUM_AXES; a++) begin
        if (w_cap[a]) r_hold[a] <= byte_data;
      end
    end
  end

  axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_x (
    .clk    (clk),
    .rst    (rst),
    .add_en (w_add),
    .clr    (w_last),
    .sample (r_hold[AXIS_X]),
    .avg    (x_avg),
    .mag    (x_mag),
    .neg    (x_neg)
  );

  axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_y (
    .clk    (clk),
    .rst    (rst),
    .add_en (w_add),
    .clr    (w_last),
    .sample (r_hold[AXIS_Y]),
    .avg    (y_avg),
    .mag    (y_mag),
    .neg    (y_neg)
  );

  axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_z (
    .clk    (clk),
    .rst    (rst),
    .add_en (w_add),
    .clr    (w_last),
    .sample (r_hold[AXIS_Z]),
    .avg    (z_avg),
    .mag    (z_mag),
    .neg    (z_neg)
  );

  assign out_valid = r_valid;
  assign frame_err = r_err;

endmodule

// File: tb/tb_accel_frame_averager.sv
// Scoreboard bench: one averager with AVG_LOG2=2 and one with
// AVG_LOG2=0 share a stimulus stream of directed read bursts.
module tb_accel_frame_averager;

  typedef struct {
    logic [2:0][7:0] a;
    int              due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic frame_end = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;

  logic [2:0][7:0] a0, a2;
  logic [2:0][6:0] m0, m2;
  logic [2:0]      n0, n2;
  logic v0, v2, e0, e2;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  exp_t q0[$];
  exp_t q2[$];
  int   qe0[$];
  int   qe2[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  accel_frame_averager #(.AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst),
    .frame_start(frame_start), .frame_end(frame_end),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .x_avg(a0[0]), .y_avg(a0[1]), .z_avg(a0[2]),
    .x_mag(m0[0]), .y_mag(m0[1]), .z_mag(m0[2]),
    .x_neg(n0[0]), .y_neg(n0[1]), .z_neg(n0[2]),
    .out_valid(v0), .frame_err(e0)
  );

  accel_frame_averager #(.AVG_LOG2(2)) dut2 (
    .clk(clk), .rst(rst),
    .frame_start(frame_start), .frame_end(frame_end),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .x_avg(a2[0]), .y_avg(a2[1]), .z_avg(a2[2]),
    .x_mag(m2[0]), .y_mag(m2[1]), .z_mag(m2[2]),
    .x_neg(n2[0]), .y_neg(n2[1]), .z_neg(n2[2]),
    .out_valid(v2), .frame_err(e2)
  );

  function automatic logic [6:0] mag_of(logic [7:0] v);
    int s;
    s = $signed(v);
    if (s < 0) s = -s;
    if (s > 127) s = 127;
    return 7'(s);
  endfunction

  task automatic cmp_out(input string nm,
                         input logic [2:0][7:0] a,
                         input logic [2:0][6:0] m,
                         input logic [2:0] n,
                         input exp_t e);
    logic [2:0][6:0] em;
    logic [2:0]      en;
    for (int k = 0; k < 3; k++) begin
      em[k] = mag_of(e.a[k]);
      en[k] = e.a[k][7];
    end
    n_chk++;
    if (a !== e.a || m !== em || n !== en || cyc != e.due) begin
      n_fail++;
      $display("FAIL %s: got avg=%h mag=%h neg=%b cyc=%0d, want avg=%h mag=%h neg=%b cyc=%0d",
               nm, a, m, n, cyc, e.a, em, en, e.due);
    end
  endtask

  task automatic cmp_err(input string nm, input int due);
    n_chk++;
    if (cyc != due) begin
      n_fail++;
      $display("FAIL %s: frame_err at cyc=%0d, want cyc=%0d",
               nm, cyc, due);
    end
  endtask

  // Monitor: pop and compare whenever a DUT strobes.
  always @(posedge clk) begin
    #1;
    if (v0) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL d0_extra_valid: out_valid=1, want 0");
      end else cmp_out("d0_out", a0, m0, n0, q0.pop_front());
    end
    if (v2) begin
      if (q2.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL d2_extra_valid: out_valid=1, want 0");
      end else cmp_out("d2_out", a2, m2, n2, q2.pop_front());
    end
    if (e0) begin
      if (qe0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL d0_extra_err: frame_err=1, want 0");
      end else cmp_err("d0_err", qe0.pop_front());
    end
    if (e2) begin
      if (qe2.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL d2_extra_err: frame_err=1, want 0");
      end else cmp_err("d2_err", qe2.pop_front());
    end
  end

  task automatic push_exp(input int n, input logic [7:0] bx,
                          input logic [7:0] by, input logic [7:0] bz,
                          input bit chk2, input logic [7:0] ex,
                          input logic [7:0] ey, input logic [7:0] ez);
    exp_t e;
    if (n >= 3) begin
      e.a = {bz, by, bx};
      e.due = cyc + 2;
      q0.push_back(e);
      if (chk2) begin
        e.a = {ez, ey, ex};
        q2.push_back(e);
      end
    end else begin
      qe0.push_back(cyc + 1);
      qe2.push_back(cyc + 1);
    end
  endtask

  // One burst; swb puts byte 0 on the frame_start cycle,
  // bwe puts frame_end on the last byte cycle.
  task automatic frame(input logic [7:0] bx, input logic [7:0] by,
                       input logic [7:0] bz, input int n,
                       input bit swb, input bit bwe,
                       input bit chk2, input logic [7:0] ex,
                       input logic [7:0] ey, input logic [7:0] ez);
    logic [7:0] b [5];
    int i;
    b[0] = bx; b[1] = by; b[2] = bz; b[3] = 8'hAA; b[4] = 8'hBB;
    i = 0;
    @(negedge clk);
    frame_start = 1'b1;
    if (swb) begin
      byte_valid = 1'b1;
      byte_data  = b[0];
      i = 1;
    end
    @(negedge clk);
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    while (i < n) begin
      byte_valid = 1'b1;
      byte_data  = b[i];
      if (bwe && i == n - 1) begin
        push_exp(n, bx, by, bz, chk2, ex, ey, ez);
        frame_end = 1'b1;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      frame_end  = 1'b0;
      i++;
      @(negedge clk);
    end
    if (!bwe) begin
      push_exp(n, bx, by, bz, chk2, ex, ey, ez);
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm,
                          input logic [2:0][7:0] a,
                          input logic [2:0][6:0] m,
                          input logic [2:0] n,
                          input logic v, input logic e);
    n_chk++;
    if (a !== '0 || m !== '0 || n !== '0 || v !== 1'b0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got avg=%h mag=%h neg=%b v=%b err=%b, want all 0",
               nm, a, m, n, v, e);
    end
  endtask

  task automatic chk_empty(input string nm, input int sz);
    n_chk++;
    if (sz != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected events never seen, want 0",
               nm, sz);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("d0_reset", a0, m0, n0, v0, e0);
    chk_zero("d2_reset", a2, m2, n2, v2, e2);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Constant window: averages equal the sample.
    repeat (3) frame(8'h04, 8'hFC, 8'h40, 3, 0, 0, 0, 0, 0, 0);
    frame(8'h04, 8'hFC, 8'h40, 3, 0, 0, 1, 8'h04, 8'hFC, 8'h40);

    // X 1,2,3,4 -> 2.
    frame(8'h01, 8'h00, 8'h00, 3, 0, 0, 0, 0, 0, 0);
    frame(8'h02, 8'h00, 8'h00, 3, 0, 0, 0, 0, 0, 0);
    frame(8'h03, 8'h00, 8'h00, 3, 0, 0, 0, 0, 0, 0);
    frame(8'h04, 8'h00, 8'h00, 3, 0, 0, 1, 8'h02, 8'h00, 8'h00);

    // Floor toward -inf, +127 and -128 extremes.
    repeat (3) frame(8'hFF, 8'h7F, 8'h80, 3, 0, 0, 0, 0, 0, 0);
    frame(8'hFE, 8'h7F, 8'h80, 3, 0, 0, 1, 8'hFE, 8'h7F, 8'h80);

    // Short burst flags an error and does not count.
    frame(8'h77, 8'h66, 8'h00, 2, 0, 0, 0, 0, 0, 0);
    // Trailing bytes ignored.
    frame(8'h10, 8'h20, 8'h30, 5, 0, 0, 0, 0, 0, 0);
    // Aborted partial burst, restarted by frame_start.
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    byte_valid  = 1'b1;
    byte_data   = 8'h55;
    @(negedge clk);
    byte_valid  = 1'b0;
    frame(8'h80, 8'h01, 8'h00, 3, 1, 0, 0, 0, 0, 0);
    frame(8'h80, 8'h01, 8'h00, 3, 0, 1, 0, 0, 0, 0);
    frame(8'h80, 8'h01, 8'h00, 3, 1, 1, 1, 8'hA4, 8'h08, 8'h0C);

    // Async reset mid-window discards the partial sums.
    repeat (2) frame(8'h11, 8'h22, 8'h33, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_zero("d0_async_rst", a0, m0, n0, v0, e0);
    chk_zero("d2_async_rst", a2, m2, n2, v2, e2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame(8'h08, 8'h01, 8'hF0, 3, 0, 0, 0, 0, 0, 0);
    frame(8'h04, 8'h01, 8'hF0, 3, 0, 0, 0, 0, 0, 0);
    frame(8'h00, 8'h01, 8'hF0, 3, 0, 0, 0, 0, 0, 0);
    frame(8'hFC, 8'h01, 8'hF0, 3, 0, 0, 1, 8'h02, 8'h01, 8'hF0);

    repeat (10) @(negedge clk);
    chk_empty("d0_pending_out", q0.size());
    chk_empty("d2_pending_out", q2.size());
    chk_empty("d0_pending_err", qe0.size());
    chk_empty("d2_pending_err", qe2.size());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_frame_averager.md
Name: accel_frame_averager

Overview:
- Sits directly downstream of the SPI master's receive path.
- Consumes the MISO byte stream of one accelerometer read burst (XDATA, YDATA, ZDATA in that order) and assembles it into a 3-axis sample.
- Averages 2^AVG_LOG2 consecutive samples per axis, then presents signed averages plus sign/magnitude fields to the seven-segment decoders with a one-cycle update strobe.

Parameters:
- AVG_LOG2, 2, log2 of averaging window in samples; legal range 0..4 (0 = every frame passes through unaveraged)

Ports:
- clk  in  1  system clock (same domain as the SPI shift logic)
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse: chip select asserted, new read burst begins
- frame_end  in  1  one-cycle pulse: chip select released, burst finished
- byte_valid  in  1  one-cycle pulse: byte_data holds a complete received byte
- byte_data  in  8  received byte (two's complement axis data)
- x_avg, y_avg, z_avg  out  8 each  signed window average per axis
- x_mag, y_mag, z_mag  out  7 each  |average|, saturated to 127
- x_neg, y_neg, z_neg  out  1 each  1 when the average is negative (drives the decimal-point sign)
- out_valid  out  1  one-cycle pulse when all avg/mag/neg outputs update
- frame_err  out  1  one-cycle pulse when a burst ends with fewer than 3 bytes

Behaviour:
- Reset (async, rst=1): all outputs 0, accumulators 0, window count 0, byte index 0, state IDLE.
- FSM states: IDLE, COLLECT, DROP, ACCUM.
  - IDLE: frame_start -> COLLECT with byte index 0; byte_valid is ignored.
  - COLLECT: each byte_valid stores byte_data into the X/Y/Z holding register selected by the index (0/1/2), then increments the index. After index 2 is stored -> DROP.
  - COLLECT + frame_end with index < 3 -> IDLE; frame_err=1 next cycle; holding registers discarded.
  - DROP: further byte_valid is ignored (trailing dummy bytes). frame_end -> ACCUM.
  - ACCUM (exactly 1 cycle): add the sign-extended X/Y/Z holding registers into the per-axis accumulators, increment the window count, then -> IDLE.
- Same-cycle events:
  - frame_start with byte_valid: the byte is captured as index 0.
  - frame_start in COLLECT or DROP: restart at index 0, no frame_err, partial data discarded.
  - byte_valid with frame_end in COLLECT: the byte is captured first, then frame_end is evaluated. If it was the 3rd byte -> ACCUM.
- Accumulator width is 8+AVG_LOG2 bits, signed; the sum of 2^AVG_LOG2 values in [-128, 127] cannot overflow.
- Window completion: when the count wraps from 2^AVG_LOG2-1 to 0 in ACCUM, the next cycle:
  - avg = accumulator (including the final sample) arithmetic-shifted right by AVG_LOG2 (floor toward -inf);
  - mag/neg are derived from avg, and avg=-128 gives mag=127, neg=1;
  - out_valid=1 and the accumulators clear to 0.
- Latency: frame_end of the final frame at cycle T -> ACCUM at T+1 -> outputs and out_valid at T+2. For AVG_LOG2=0, every good frame produces out_valid at T+2.
- Outputs hold their value between out_valid pulses; they never glitch mid-window.
- frame_err does not disturb the accumulators or the window count.

Decomposition:
- Package accel_pkg:
  - state enum typedef (IDLE, COLLECT, DROP, ACCUM);
  - localparam BYTES_PER_FRAME=3, NUM_AXES=3;
  - axis index constants AXIS_X=0, AXIS_Y=1, AXIS_Z=2.
- Sub-module axis_accumulator, instantiated 3×:
  - inputs: clk, rst, add_en, clr, sample[7:0];
  - outputs: avg[7:0], mag[6:0], neg;
  - holds the accumulator plus the sign/magnitude conversion with saturation.
- The top module holds the FSM, byte index, window counter and strobes.

Test Plan:
- AVG_LOG2=2; 4 frames of {0x04, 0xFC, 0x40} -> one out_valid 2 cycles after the 4th frame_end; x_avg=0x04, y_avg=0xFC, z_avg=0x40; x_mag=4/x_neg=0, y_mag=4/y_neg=1.
- AVG_LOG2=2; X bytes 1,2,3,4 -> x_avg=2. X bytes 0xFF,0xFF,0xFF,0xFE (sum -5) -> x_avg=0xFE, x_mag=2, x_neg=1.
- Short frame of 2 bytes then frame_end -> frame_err pulse, no out_valid. Four further good frames are needed before out_valid.
- Frame with 5 bytes {0x10, 0x20, 0x30, 0xAA, 0xBB}, AVG_LOG2=0 -> x/y/z_avg=0x10/0x20/0x30 (extra bytes ignored).
- AVG_LOG2=0, X=0x80 -> x_avg=0x80, x_mag=127, x_neg=1.
- Assert rst asynchronously after 2 good frames (AVG_LOG2=2) -> outputs 0 immediately. out_valid appears only after 4 new frames, with averages reflecting only those frames.
